issueq_int: RTL
===============

// Module: issueq_int
// PURPOSE
//  Integer issue queue (reservation station) directly upstream of the issue/CDB stage.
//  - Holds dispatched integer ops until both source operands are valid.
//  - Snoops the CDB to wake up waiting operands.
//  - Presents the oldest ready op on issueint_*, holding it until the issue stage answers issueint_equeueint_done.
// PARAMETERS
//  DEPTH   8   number of entries (2..16)
//  TAG_W   6   ROB/physical tag width
//  DATA_W  32  operand width
//  OP_W    6   ALU opcode width
// PORTS
//  clk                      in   1       single clock, rising edge
//  reset                    in   1       asynchronous, active-low; clears all state
//  dispatch_en              in   1       write one op this cycle (ignored when issueq_full)
//  dispatch_opcode          in   OP_W    ALU opcode
//  dispatch_rsdata          in   DATA_W  rs value (meaningful if dispatch_rsvalid)
//  dispatch_rstag           in   TAG_W   rs producer tag
//  dispatch_rsvalid         in   1       rs value already available
//  dispatch_rtdata          in   DATA_W  rt value
//  dispatch_rttag           in   TAG_W   rt producer tag
//  dispatch_rtvalid         in   1       rt value already available
//  dispatch_rdtag           in   TAG_W   destination tag
//  cdb_valid                in   1       CDB broadcast valid
//  cdb_tag                  in   TAG_W   CDB tag
//  cdb_data                 in   DATA_W  CDB data
//  issueint_equeueint_done  in   1       issue stage accepted presented op
//  issueq_full              out  1       count == DEPTH
//  issueq_count             out  5       occupied entries
//  issueint_ready           out  1       a ready op is presented
//  issueint_opcode          out  OP_W    presented opcode
//  issueint_rsdata          out  DATA_W  presented rs
//  issueint_rtdata          out  DATA_W  presented rt
//  issueint_rdtag           out  TAG_W   presented dest tag
// BEHAVIOUR
//  Reset:
//  - All entry valid bits are 0; count is 0.
//  - issueint_ready=0, issueq_full=0, all issueint_* data outputs 0.
//  Storage:
//  - Compacting, age-ordered array; slot 0 is the oldest.
//  - Entry holds: busy, opcode, rs/rt data, tags, valid flags, rdtag.
//  Select:
//  - Combinational from registered state only.
//  - Picks the lowest-index busy entry with rsvalid & rtvalid and drives issueint_*.
//  - If none is ready, issueint_ready=0 and data outputs are 0.
//  Handshake:
//  - Issue stage samples issueint_* and raises done in the same cycle.
//  - done while issueint_ready=1 removes the selected entry at the next edge.
//  - Entries above the removed one shift down one slot.
//  - done while ready=0 is ignored.
//  - Without done, the selection persists, but a newly ready older entry may displace it.
//  Dispatch:
//  - Written to the first free slot after this cycle's compaction.
//  - Accepted only when the registered count < DEPTH; issue and dispatch in the same cycle at full is rejected.
//  - count' = count + accepted_dispatch - accepted_issue.
//  Wakeup:
//  - cdb_valid & tag match on a busy, not-yet-valid operand sets valid and captures cdb_data at the edge.
//  - This also applies to an entry being shifted in the same cycle.
//  - Woken operands become selectable the cycle after the broadcast (1-cycle wakeup-to-select).
//  - A dispatch whose rstag/rttag matches the same-cycle CDB broadcast (and whose valid=0) is written as valid with cdb_data (bypass).
//  - Both operands may wake on one broadcast.
//  Latency:
//  - Dispatch of a fully ready op -> issueint_ready the next cycle.
// CONFIGURATION
//  ISSUEQ_FLUSH_EN:
//  - When defined, adds input flush (1).
//  - flush=1 clears all busy bits at the next edge; count becomes 0.
//  - flush overrides same-cycle dispatch, issue and wakeup.
//  - When undefined, there is no flush port and the queue drains only via issue.
// STRUCTURE
//  - globals.vh gets `ISSUEQ_DEPTH, `ISSUEQ_TAG_W and the entry field widths.
//  - Sub-module issueq_entry: one slot. It holds the registers, tag-match wakeup, shift-in mux and ready output.
//  - The top level holds the age priority select, compaction control and count.
// TESTING
//  1. Reset mid-operation with 3 entries -> next cycle count=0, ready=0, full=0.
//  2. Dispatch add, both valid, rs=5 rt=7 rdtag=3 -> next cycle ready=1, rsdata=5, rtdata=7, rdtag=3; done -> count 0.
//  3. Dispatch with rstag=9 invalid; CDB tag 9 data 0x1234 two cycles later -> ready the cycle after, rsdata=0x1234.
//  4. Dispatch rttag=4 invalid while cdb_valid=1, tag 4, data 0xAA -> bypassed; ready next cycle, rtdata=0xAA.
//  5. Fill 8 entries; entries 0 and 2 ready; done -> entry 0 removed, old entry 2 now in slot 1 and presented; 9th dispatch at full rejected.
//  6. Three ready entries; done held high 3 cycles -> issued oldest-first, count 3->0.
//     (ISSUEQ_FLUSH_EN) flush with 5 entries plus dispatch -> count=0 next cycle.

Source files
------------

// File: rtl/issueq_int_pkg.sv
// Shared widths, entry record and CDB wakeup helper for the integer issue queue.
package issueq_int_pkg;

  localparam int IQ_DEPTH = 8;
  localparam int TAG_W    = 6;
  localparam int DATA_W   = 32;
  localparam int OP_W     = 6;
  localparam int CNT_W    = 5;

  typedef enum logic [1:0] {
    SEL_KEEP,
    SEL_SHIFT,
    SEL_DISP,
    SEL_CLEAR
  } slot_sel_e;

  typedef struct packed {
    logic              busy;
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] rs_data;
    logic [TAG_W-1:0]  rs_tag;
    logic              rs_valid;
    logic [DATA_W-1:0] rt_data;
    logic [TAG_W-1:0]  rt_tag;
    logic              rt_valid;
    logic [TAG_W-1:0]  rd_tag;
  } entry_t;

  // Applies a CDB broadcast to a live entry; an invalid entry is returned untouched.
  function automatic entry_t cdb_wake(entry_t e, logic cdb_valid,
                                      logic [TAG_W-1:0] cdb_tag,
                                      logic [DATA_W-1:0] cdb_data);
    entry_t r;
    r = e;
    if (cdb_valid && e.busy && !e.rs_valid && e.rs_tag == cdb_tag) begin
      r.rs_valid = 1'b1;
      r.rs_data  = cdb_data;
    end
    if (cdb_valid && e.busy && !e.rt_valid && e.rt_tag == cdb_tag) begin
      r.rt_valid = 1'b1;
      r.rt_data  = cdb_data;
    end
    return r;
  endfunction

endpackage

// File: rtl/issueq_int_if.sv
// Dispatch, CDB and issue-side signals of the integer issue queue.
interface issueq_int_if;
  import issueq_int_pkg::*;

  logic              dispatch_en;
  logic [OP_W-1:0]   dispatch_opcode;
  logic [DATA_W-1:0] dispatch_rsdata;
  logic [TAG_W-1:0]  dispatch_rstag;
  logic              dispatch_rsvalid;
  logic [DATA_W-1:0] dispatch_rtdata;
  logic [TAG_W-1:0]  dispatch_rttag;
  logic              dispatch_rtvalid;
  logic [TAG_W-1:0]  dispatch_rdtag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              issueint_equeueint_done;
  logic              issueq_full;
  logic [CNT_W-1:0]  issueq_count;
  logic              issueint_ready;
  logic [OP_W-1:0]   issueint_opcode;
  logic [DATA_W-1:0] issueint_rsdata;
  logic [DATA_W-1:0] issueint_rtdata;
  logic [TAG_W-1:0]  issueint_rdtag;

  modport master (
    output dispatch_en, dispatch_opcode, dispatch_rsdata, dispatch_rstag, dispatch_rsvalid,
           dispatch_rtdata, dispatch_rttag, dispatch_rtvalid, dispatch_rdtag,
           cdb_valid, cdb_tag, cdb_data, issueint_equeueint_done,
    input  issueq_full, issueq_count, issueint_ready, issueint_opcode,
           issueint_rsdata, issueint_rtdata, issueint_rdtag
  );

  modport slave (
    input  dispatch_en, dispatch_opcode, dispatch_rsdata, dispatch_rstag, dispatch_rsvalid,
           dispatch_rtdata, dispatch_rttag, dispatch_rtvalid, dispatch_rdtag,
           cdb_valid, cdb_tag, cdb_data, issueint_equeueint_done,
    output issueq_full, issueq_count, issueint_ready, issueint_opcode,
           issueint_rsdata, issueint_rtdata, issueint_rdtag
  );
endinterface

// File: rtl/issueq_entry.sv
// One issue-queue slot: entry registers, shift-in/dispatch mux, CDB wakeup, ready flag.
module issueq_entry
  import issueq_int_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  slot_sel_e         sel_i,
  input  entry_t            up_i,
  input  entry_t            disp_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  output entry_t            ent_o,
  output logic              ready_o
);

  entry_t ent_q, ent_d, src;

  // NOTE: every case arm assigns src, and a default covers the rest, so no latch is inferred.
  always_comb begin
    src = ent_q;
    unique case (sel_i)
      SEL_KEEP:  src = ent_q;
      SEL_SHIFT: src = up_i;
      SEL_DISP:  src = disp_i;
      SEL_CLEAR: src = '0;
      default:   src = ent_q;
    endcase
    ent_d = cdb_wake(src, cdb_valid_i, cdb_tag_i, cdb_data_i);
  end

  // NOTE: the payload is reset along with busy so the idle issue outputs read as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ent_q <= '0;
    else        ent_q <= ent_d;
  end

  assign ent_o   = ent_q;
  assign ready_o = ent_q.busy & ent_q.rs_valid & ent_q.rt_valid;

endmodule

// File: rtl/issueq_int.sv
// Integer issue queue: compacting age-ordered slots, oldest-ready select, count.
// Optional flush input is enabled by defining ISSUEQ_FLUSH_EN.
module issueq_int
  import issueq_int_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
`ifdef ISSUEQ_FLUSH_EN
  input  logic       flush,
`endif
  issueq_int_if.slave bus
);

  entry_t             ent [DEPTH];
  logic [DEPTH-1:0]   rdy;
  entry_t             sel_ent, disp_ent;
  logic [CNT_W-1:0]   count_q, count_d, sel_idx, wr_idx;
  logic               any_rdy, issue, accept, flush_w;

`ifdef ISSUEQ_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Lowest index wins: slot 0 always holds the oldest entry.
  always_comb begin
    any_rdy = 1'b0;
    sel_idx = '0;
    sel_ent = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        any_rdy = 1'b1;
        sel_idx = CNT_W'(i);
        sel_ent = ent[i];
      end
    end
  end

  assign issue  = bus.issueint_equeueint_done & any_rdy;
  assign accept = bus.dispatch_en && (count_q < CNT_W'(DEPTH));
  assign wr_idx = count_q - CNT_W'(issue);

  always_comb begin
    disp_ent          = '0;
    disp_ent.busy     = 1'b1;
    disp_ent.opcode   = bus.dispatch_opcode;
    disp_ent.rs_data  = bus.dispatch_rsdata;
    disp_ent.rs_tag   = bus.dispatch_rstag;
    disp_ent.rs_valid = bus.dispatch_rsvalid;
    disp_ent.rt_data  = bus.dispatch_rtdata;
    disp_ent.rt_tag   = bus.dispatch_rttag;
    disp_ent.rt_valid = bus.dispatch_rtvalid;
    disp_ent.rd_tag   = bus.dispatch_rdtag;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    localparam logic [CNT_W-1:0] SLOT = CNT_W'(g);
    entry_t    up;
    slot_sel_e slot_sel;

    if (g == DEPTH - 1) begin : g_top
      assign up = '0;
    end else begin : g_mid
      assign up = ent[g+1];
    end

    // Dispatch lands on the first free slot after this cycle's compaction.
    always_comb begin
      if (flush_w)                        slot_sel = SEL_CLEAR;
      else if (accept && wr_idx == SLOT)  slot_sel = SEL_DISP;
      else if (issue && SLOT >= sel_idx)  slot_sel = SEL_SHIFT;
      else                                slot_sel = SEL_KEEP;
    end

    issueq_entry u_entry (
      .clk         (clk),
      .reset       (reset),
      .sel_i       (slot_sel),
      .up_i        (up),
      .disp_i      (disp_ent),
      .cdb_valid_i (bus.cdb_valid),
      .cdb_tag_i   (bus.cdb_tag),
      .cdb_data_i  (bus.cdb_data),
      .ent_o       (ent[g]),
      .ready_o     (rdy[g])
    );
  end

  assign count_d = flush_w ? '0 : count_q + CNT_W'(accept) - CNT_W'(issue);

  // NOTE: sequential state uses non-blocking assignment so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign bus.issueq_count    = count_q;
  assign bus.issueq_full     = (count_q == CNT_W'(DEPTH));
  assign bus.issueint_ready  = any_rdy;
  assign bus.issueint_opcode = sel_ent.opcode;
  assign bus.issueint_rsdata = sel_ent.rs_data;
  assign bus.issueint_rtdata = sel_ent.rt_data;
  assign bus.issueint_rdtag  = sel_ent.rd_tag;

endmodule
